pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Top-level game sequencer for Pong. Drives the mode/status inputs of the renderer
//  (game_startup, game_over, sq_shown, score_p1/p2) and gates the ball/paddle physics
//  (play_en, ball_reset, serve_dir). Sits between the debounced start button, the ball
//  physics miss detectors and pong_renderer. All timing is counted in video frames.
// PARAMETERS
//  WIN_SCORE     7    score that ends the game (1..15)
//  SERVE_FRAMES  90   frames the ball is held at centre before each serve (>=1)
//  BLINK_FRAMES  8    ball blink half-period during serve, in frames (>=1)
//  OVER_FRAMES   300  frames on game-over screen before auto-return to startup (>=1)
// PORTS
//  clk_0       in   1  25.175 MHz pixel clock
//  rst         in   1  synchronous reset, active-high
//  frame_tick  in   1  one-cycle pulse per frame (start of vertical blank)
//  btn_start   in   1  debounced start button, level, active-high
//  miss_p1     in   1  one-cycle pulse: ball left playfield past paddle 1 (point to P2)
//  miss_p2     in   1  one-cycle pulse: ball left playfield past paddle 2 (point to P1)
//  game_startup out 1  high in IDLE (startup menu shown)
//  game_over   out  1  high in OVER
//  sq_shown    out  1  ball visible
//  play_en     out  1  physics may move ball/paddles
//  ball_reset  out  1  physics holds ball at centre
//  serve_dir   out  1  0 = serve toward P1 (left), 1 = toward P2 (right)
//  score_p1    out  4  player 1 score
//  score_p2    out  4  player 2 score
//  winner      out  1  0 = P1 won, 1 = P2 won; valid in OVER
// BEHAVIOUR
//  - All outputs registered; respond the cycle after the causing input edge/pulse.
//  - Reset (any cycle, any state): state=IDLE, game_startup=1, all other 1-bit outputs 0,
//    scores 0, frame/blink counters 0, start edge detector primed (start_q<=btn_start so a
//    button held through reset does not count as a press).
//  - start_rise = btn_start & ~start_q, one cycle per press.
//  - States:
//    IDLE : game_startup=1, play_en=0, sq_shown=0. start_rise -> clear scores, serve_dir=1,
//           frame_cnt=0, -> SERVE.
//    SERVE: ball_reset=1, play_en=0. frame_cnt increments on frame_tick. sq_shown=1 on
//           entry, toggles every BLINK_FRAMES frame_ticks. On frame_tick with
//           frame_cnt==SERVE_FRAMES-1 -> PLAY (frame_cnt cleared).
//    PLAY : play_en=1, ball_reset=0, sq_shown=1.
//           miss_p1 only: score_p2+1, serve_dir=0 (serve toward conceding player).
//           miss_p2 only: score_p1+1, serve_dir=1.
//           miss_p1 & miss_p2 same cycle: no score change, serve_dir unchanged, -> SERVE.
//           After a single miss: if new score==WIN_SCORE -> OVER, winner set; else -> SERVE.
//    OVER : game_over=1, play_en=0, sq_shown=0, scores frozen. frame_cnt counts frame_ticks;
//           start_rise or frame_tick with frame_cnt==OVER_FRAMES-1 -> IDLE. start_rise in
//           OVER goes to IDLE only (a second press starts a new game).
//  - miss pulses outside PLAY ignored; start_rise outside IDLE/OVER ignored.
//  - frame_tick and a state transition in the same cycle: transition wins, counter cleared.
//  - Scores never exceed WIN_SCORE (game ends on reaching it); no 4-bit wrap possible.
//  - Exactly one of game_startup/game_over/play_en/ball_reset is high in every state.
// TESTING
//  1 rst=1 with btn_start=1, release rst, hold btn -> stays IDLE, game_startup=1, scores 0.
//  2 IDLE, press start -> next cycle SERVE, ball_reset=1, serve_dir=1; sq_shown toggles
//    after 8 ticks; PLAY entered on the 90th frame_tick, play_en=1, sq_shown=1.
//  3 PLAY, miss_p1 pulse -> score_p2=1, serve_dir=0, SERVE; miss_p2 pulse -> score_p1=1.
//  4 PLAY, miss_p1 and miss_p2 same cycle -> scores unchanged, SERVE.
//  5 score_p1=6, miss_p2 -> score_p1=7, game_over=1, winner=0; misses now ignored; after
//    300 frame_ticks -> IDLE; second run: start press in OVER -> IDLE immediately.
//  6 rst pulse mid-PLAY with scores 3:5 -> IDLE, scores 0, play_en=0 next cycle.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start menu, serve hold with ball blink, live play, game-over screen.
// Every output is registered and reflects the cycle's inputs one clock later.
module pong_game_ctrl #(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 90,
   parameter int BLINK_FRAMES = 8,
   parameter int OVER_FRAMES  = 300
) (
   input  logic       clk_0,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       btn_start,
   input  logic       miss_p1,
   input  logic       miss_p2,
   output logic       game_startup,
   output logic       game_over,
   output logic       sq_shown,
   output logic       play_en,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic       winner,
   output logic [1:0] state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SERVE = 2'd1;
   localparam logic [1:0] S_PLAY  = 2'd2;
   localparam logic [1:0] S_OVER  = 2'd3;

   localparam int CNT_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BLK_W   = $clog2(BLINK_FRAMES + 1);

   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
   localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);

   logic             start_q;
   logic             start_rise;
   logic [CNT_W-1:0] frame_cnt, n_frame;
   logic [BLK_W-1:0] blink_cnt, n_blink;
   logic [1:0]       n_state;
   logic             n_sq, n_dir, n_win;
   logic [3:0]       n_p1, n_p2, p1_inc, p2_inc;

   assign start_rise = btn_start & ~start_q;
   assign p1_inc     = score_p1 + 4'd1;
   assign p2_inc     = score_p2 + 4'd1;

   always_comb begin
      n_state = state;
      n_frame = frame_cnt;
      n_blink = blink_cnt;
      n_sq    = sq_shown;
      n_p1    = score_p1;
      n_p2    = score_p2;
      n_dir   = serve_dir;
      n_win   = winner;
      case (state)
         S_IDLE: begin
            if (start_rise) begin
               n_state = S_SERVE;
               n_p1    = 4'd0;
               n_p2    = 4'd0;
               n_dir   = 1'b1;
            end
         end
         S_SERVE: begin
            if (frame_tick) begin
               if (frame_cnt == SERVE_LAST) begin
                  n_state = S_PLAY;
               end else begin
                  n_frame = frame_cnt + 1'b1;
                  if (blink_cnt == BLINK_LAST) begin
                     n_blink = '0;
                     n_sq    = ~sq_shown;
                  end else begin
                     n_blink = blink_cnt + 1'b1;
                  end
               end
            end
         end
         S_PLAY: begin
            if (miss_p1 && miss_p2) begin
               n_state = S_SERVE;
            end else if (miss_p1) begin
               n_p2    = p2_inc;
               n_dir   = 1'b0;
               n_state = (p2_inc == WIN_VAL) ? S_OVER : S_SERVE;
               n_win   = (p2_inc == WIN_VAL) ? 1'b1 : winner;
            end else if (miss_p2) begin
               n_p1    = p1_inc;
               n_dir   = 1'b1;
               n_state = (p1_inc == WIN_VAL) ? S_OVER : S_SERVE;
               n_win   = (p1_inc == WIN_VAL) ? 1'b0 : winner;
            end
         end
         default: begin
            if (start_rise || (frame_tick && frame_cnt == OVER_LAST)) begin
               n_state = S_IDLE;
            end else if (frame_tick) begin
               n_frame = frame_cnt + 1'b1;
            end
         end
      endcase

      // Any transition restarts frame timing, even if a frame_tick arrived alongside it.
      if (n_state != state) begin
         n_frame = '0;
         n_blink = '0;
      end
      case (n_state)
         S_SERVE: if (state != S_SERVE) n_sq = 1'b1;
         S_PLAY:  n_sq = 1'b1;
         default: n_sq = 1'b0;
      endcase
   end

   always_ff @(posedge clk_0) begin
      start_q <= btn_start;
      if (rst) begin
         state        <= S_IDLE;
         frame_cnt    <= '0;
         blink_cnt    <= '0;
         game_startup <= 1'b1;
         game_over    <= 1'b0;
         play_en      <= 1'b0;
         ball_reset   <= 1'b0;
         sq_shown     <= 1'b0;
         serve_dir    <= 1'b0;
         winner       <= 1'b0;
         score_p1     <= 4'd0;
         score_p2     <= 4'd0;
      end else begin
         state        <= n_state;
         frame_cnt    <= n_frame;
         blink_cnt    <= n_blink;
         game_startup <= (n_state == S_IDLE);
         game_over    <= (n_state == S_OVER);
         play_en      <= (n_state == S_PLAY);
         ball_reset   <= (n_state == S_SERVE);
         sq_shown     <= n_sq;
         serve_dir    <= n_dir;
         winner       <= n_win;
         score_p1     <= n_p1;
         score_p2     <= n_p2;
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: reset priming, serve timing and blink, scoring,
// double miss, win and timed/pressed return to the menu, reset during play.
module tb_pong_game_ctrl;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SERVE = 2'd1;
   localparam logic [1:0] S_PLAY  = 2'd2;
   localparam logic [1:0] S_OVER  = 2'd3;

   logic       clk_0 = 1'b0;
   logic       rst, frame_tick, btn_start, miss_p1, miss_p2;
   logic       game_startup, game_over, sq_shown, play_en, ball_reset, serve_dir, winner;
   logic [3:0] score_p1, score_p2;
   logic [1:0] state;

   int n_cmp = 0;
   int n_err = 0;

   pong_game_ctrl #(
      .WIN_SCORE(7), .SERVE_FRAMES(90), .BLINK_FRAMES(8), .OVER_FRAMES(300)
   ) dut (
      .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .btn_start(btn_start),
      .miss_p1(miss_p1), .miss_p2(miss_p2), .game_startup(game_startup),
      .game_over(game_over), .sq_shown(sq_shown), .play_en(play_en),
      .ball_reset(ball_reset), .serve_dir(serve_dir), .score_p1(score_p1),
      .score_p2(score_p2), .winner(winner), .state(state)
   );

   always #20 clk_0 = ~clk_0;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic cyc();
      @(posedge clk_0);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks the state plus the mode output that must be the only one high.
   task automatic chk_mode(input string tag, input logic [1:0] exp_state);
      logic [3:0] exp_modes;
      exp_modes = 4'b0001 << exp_state;
      chk({tag, ".state"}, 16'(state), 16'(exp_state));
      chk({tag, ".modes"}, 16'({ball_reset & (play_en | game_over), game_over, play_en,
                                 ball_reset, game_startup}),
          16'({1'b0, exp_modes[3], exp_modes[2], exp_modes[1], exp_modes[0]}));
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic press();
      btn_start = 1'b1;
      cyc();
      btn_start = 1'b0;
      cyc();
   endtask

   task automatic miss(input logic m1, input logic m2);
      miss_p1 = m1;
      miss_p2 = m2;
      cyc();
      miss_p1 = 1'b0;
      miss_p2 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; frame_tick = 1'b0; btn_start = 1'b1; miss_p1 = 1'b0; miss_p2 = 1'b0;
      // 1: button held through reset is not a press
      cyc(); cyc();
      chk_mode("rst", S_IDLE);
      rst = 1'b0;
      cyc(); cyc(); cyc();
      chk_mode("held_btn", S_IDLE);
      chk("held_btn.scores", 16'({score_p1, score_p2}), 16'h00);
      chk("held_btn.sq", 16'(sq_shown), 16'h0);
      btn_start = 1'b0;
      cyc();

      // 2: start, serve blink and serve duration
      btn_start = 1'b1;
      cyc();
      chk_mode("start", S_SERVE);
      chk("start.dir_sq", 16'({serve_dir, sq_shown}), 16'b11);
      btn_start = 1'b0;
      cyc();
      ticks(7);
      chk("blink7.sq", 16'(sq_shown), 16'h1);
      tick();
      chk("blink8.sq", 16'(sq_shown), 16'h0);
      btn_start = 1'b1; cyc(); btn_start = 1'b0; cyc();
      chk_mode("start_in_serve", S_SERVE);
      ticks(81);
      chk("serve89.sq", 16'(sq_shown), 16'h0);
      chk_mode("serve89", S_SERVE);
      tick();
      chk_mode("serve90", S_PLAY);
      chk("play.sq", 16'(sq_shown), 16'h1);

      // 3: single misses
      miss(1'b1, 1'b0);
      chk_mode("miss_p1", S_SERVE);
      chk("miss_p1.scores", 16'({score_p1, score_p2}), 16'h01);
      chk("miss_p1.dir_sq", 16'({serve_dir, sq_shown}), 16'b01);
      miss(1'b1, 1'b1);
      chk("miss_in_serve.scores", 16'({score_p1, score_p2}), 16'h01);
      ticks(90);
      miss(1'b0, 1'b1);
      chk("miss_p2.scores", 16'({score_p1, score_p2}), 16'h11);
      chk("miss_p2.dir", 16'(serve_dir), 16'h1);

      // 4: simultaneous misses score nobody
      ticks(90);
      chk_mode("pre_both", S_PLAY);
      miss(1'b1, 1'b1);
      chk_mode("both", S_SERVE);
      chk("both.scores", 16'({score_p1, score_p2}), 16'h11);
      chk("both.dir", 16'(serve_dir), 16'h1);

      // 5: P1 reaches 7, timed return to menu
      for (int i = 0; i < 5; i++) begin
         ticks(90);
         miss(1'b0, 1'b1);
      end
      chk("six.scores", 16'({score_p1, score_p2}), 16'h61);
      ticks(90);
      miss(1'b0, 1'b1);
      chk_mode("p1_win", S_OVER);
      chk("p1_win.score_win_sq", 16'({score_p1, winner, sq_shown}), 16'b0111_0_0);
      miss(1'b1, 1'b0);
      cyc();
      chk("over_miss.scores", 16'({score_p1, score_p2}), 16'h71);
      ticks(299);
      chk_mode("over299", S_OVER);
      tick();
      chk_mode("over300", S_IDLE);
      chk("idle.scores", 16'({score_p1, score_p2}), 16'h71);

      // Second game: start coincides with a frame tick; P2 wins, start press leaves OVER
      btn_start = 1'b1; frame_tick = 1'b1;
      cyc();
      btn_start = 1'b0; frame_tick = 1'b0;
      chk("game2.scores", 16'({score_p1, score_p2}), 16'h00);
      cyc();
      ticks(89);
      chk_mode("tick_on_start89", S_SERVE);
      tick();
      chk_mode("tick_on_start90", S_PLAY);
      miss(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         ticks(90);
         miss(1'b1, 1'b0);
      end
      chk_mode("p2_win", S_OVER);
      chk("p2_win.score_win", 16'({score_p2, winner}), 16'b0111_1);
      ticks(5);
      btn_start = 1'b1;
      cyc();
      chk_mode("over_press", S_IDLE);
      cyc();
      chk_mode("over_press_hold", S_IDLE);
      btn_start = 1'b0;
      cyc();
      press();
      chk_mode("game3", S_SERVE);

      // 6: reset in the middle of play at 3:5
      for (int i = 0; i < 8; i++) begin
         ticks(90);
         miss(i >= 3, i < 3);
      end
      ticks(90);
      chk("pre_rst.scores", 16'({score_p1, score_p2}), 16'h35);
      chk_mode("pre_rst", S_PLAY);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk_mode("mid_rst", S_IDLE);
      chk("mid_rst.scores", 16'({score_p1, score_p2}), 16'h00);
      chk("mid_rst.bits", 16'({play_en, sq_shown, serve_dir, winner}), 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
